// File: rtl/io_uart_pkg.sv
// Shared constants for the memory-mapped UART transmitter: register map,
// load/store size codes, transmit FSM states and STATUS bit positions.
package io_uart_pkg;

    localparam logic [1:0] REG_TXDATA  = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_DIVISOR = 2'd2;
    localparam logic [1:0] REG_RSVD    = 2'd3;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } tx_state_e;

    localparam int STAT_EMPTY   = 0;
    localparam int STAT_FULL    = 1;
    localparam int STAT_BUSY    = 2;
    localparam int STAT_OVF     = 3;
    localparam int STAT_CNT_LSB = 8;

endpackage

// File: rtl/io_tx_fifo.sv
// Byte-wide TX FIFO. A push while full is accepted only when a pop happens on
// the same edge; a pop while empty is ignored.
module io_tx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_i,
    input  logic [7:0]                   din_i,
    input  logic                         pop_i,
    output logic [7:0]                   dout_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/io_uart_tx.sv
// UART transmitter on the CPU IO bus: register decode, combinational read mux,
// TX FIFO and an 8N1 bit-timer FSM driving a registered serial line.
module io_uart_tx
    import io_uart_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE   = 32'h0000_8000,
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [15:0] DEFAULT_DIV = 16'd16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] io_address,
    input  logic [31:0] io_write_value,
    output logic [31:0] io_read_value,
    input  logic        io_write_en,
    input  logic        io_read_en,
    input  logic [2:0]  io_data_size,
    output logic        uart_tx,
    output logic        tx_irq
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic          sel;
    logic [1:0]    reg_idx;
    logic          wr_sel;
    logic          push_req, push_ok, pop;
    logic [7:0]    fifo_dout;
    logic          fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;

    logic          overflow_q;
    logic [15:0]   div_q, div_eff;

    tx_state_e     state_q;
    logic [15:0]   timer_q, bit_div_q;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    shift_q;
    logic          tx_q, irq_q;
    logic          bit_done;

    logic [31:0]   reg_val, sized_val;
    logic          unused_bits;

    assign sel      = (io_address[31:4] == ADDR_BASE[31:4]);
    assign reg_idx  = io_address[3:2];
    assign wr_sel   = io_write_en && sel;
    assign push_req = wr_sel && (reg_idx == REG_TXDATA);
    assign pop      = (state_q == S_IDLE) && !fifo_empty;
    assign push_ok  = push_req && (!fifo_full || pop);

    assign unused_bits = ^{io_address[1:0], io_write_value[31:16]};

    io_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_ok),
        .din_i   (io_write_value[7:0]),
        .pop_i   (pop),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q <= 1'b0;
            div_q      <= DEFAULT_DIV;
        end else begin
            if (push_req && !push_ok) begin
                overflow_q <= 1'b1;
            end else if (wr_sel && reg_idx == REG_STATUS && io_write_value[STAT_OVF]) begin
                overflow_q <= 1'b0;
            end
            if (wr_sel && reg_idx == REG_DIVISOR) begin
                if (io_data_size == SZ_B || io_data_size == SZ_BU) begin
                    div_q[7:0] <= io_write_value[7:0];
                end else begin
                    div_q <= io_write_value[15:0];
                end
            end
        end
    end

    assign div_eff  = (div_q == 16'd0) ? 16'd1 : div_q;
    assign bit_done = (timer_q == bit_div_q - 16'd1);

    // Each bit latches its own length, so a divisor change lands on the next bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            timer_q   <= 16'd0;
            bit_div_q <= 16'd1;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'd0;
            tx_q      <= 1'b1;
            irq_q     <= 1'b1;
        end else begin
            irq_q <= fifo_empty && (state_q == S_IDLE);
            case (state_q)
                S_IDLE: begin
                    tx_q <= 1'b1;
                    if (pop) begin
                        shift_q   <= fifo_dout;
                        timer_q   <= 16'd0;
                        bit_div_q <= div_eff;
                        tx_q      <= 1'b0;
                        state_q   <= S_START;
                    end
                end
                S_START: begin
                    if (bit_done) begin
                        timer_q   <= 16'd0;
                        bit_div_q <= div_eff;
                        bit_cnt_q <= 3'd0;
                        tx_q      <= shift_q[0];
                        shift_q   <= {1'b0, shift_q[7:1]};
                        state_q   <= S_DATA;
                    end else begin
                        timer_q <= timer_q + 16'd1;
                    end
                end
                S_DATA: begin
                    if (bit_done) begin
                        timer_q   <= 16'd0;
                        bit_div_q <= div_eff;
                        if (bit_cnt_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= S_STOP;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            tx_q      <= shift_q[0];
                            shift_q   <= {1'b0, shift_q[7:1]};
                        end
                    end else begin
                        timer_q <= timer_q + 16'd1;
                    end
                end
                S_STOP: begin
                    if (bit_done) begin
                        timer_q <= 16'd0;
                        tx_q    <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        timer_q <= timer_q + 16'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign uart_tx = tx_q;
    assign tx_irq  = irq_q;

    always_comb begin
        reg_val = 32'd0;
        case (reg_idx)
            REG_STATUS: begin
                reg_val[STAT_CNT_LSB +: 4] = 4'(fifo_count);
                reg_val[STAT_OVF]          = overflow_q;
                reg_val[STAT_BUSY]         = (state_q != S_IDLE);
                reg_val[STAT_FULL]         = fifo_full;
                reg_val[STAT_EMPTY]        = fifo_empty;
            end
            REG_DIVISOR: reg_val = {16'd0, div_q};
            default:     reg_val = 32'd0;
        endcase
    end

    always_comb begin
        case (io_data_size)
            SZ_B:    sized_val = {{24{reg_val[7]}}, reg_val[7:0]};
            SZ_H:    sized_val = {{16{reg_val[15]}}, reg_val[15:0]};
            SZ_BU:   sized_val = {24'd0, reg_val[7:0]};
            SZ_HU:   sized_val = {16'd0, reg_val[15:0]};
            default: sized_val = reg_val;
        endcase
    end

    assign io_read_value = (io_read_en && sel) ? sized_val : 32'd0;

endmodule
